icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Refill engine on the memory side of instr_cache_L1. It accepts a miss indication and miss PC from the fetch stage and issues sequential word reads to the backing instruction memory through a valid/ack handshake. It writes each returned word into the L1 through the cache's write interface, together with that word's index and tag. Fetch stays stalled for the whole refill.

Parameters:
LINE_WORDS, 4, words per refill burst; power of two, 1..8
INDEX_W, 7, cache index width, taken from pc[8:2]
TAG_W, 23, tag width, taken from pc[31:9]

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
miss_cache  input  1  miss flag from the L1
miss_pc  input  32  PC that missed; sampled on acceptance
mem_req  output  1  read request to instruction memory
mem_addr  output  32  word-aligned byte address; bits [1:0] always 0
mem_ack  input  1  memory returns data this cycle
mem_rdata  input  32  read data, valid when mem_ack=1
save_to_cache  output  1  one-cycle write strobe to the L1
cache_input  output  32  write data to the L1
fill_index  output  INDEX_W  L1 line index being written
fill_tag  output  TAG_W  tag written alongside the data
refill_busy  output  1  stall to fetch; high from acceptance until DONE ends
refill_done  output  1  one-cycle pulse when the burst completes

Behaviour:
- Reset (synchronous, active-high): state=IDLE, word counter=0. All outputs are 0.
- A reset asserted mid-burst aborts the burst on the next edge: mem_req drops and no further save_to_cache is issued. Partially written words stay in the cache.
- FSM states: IDLE, REQ, WRITE, DONE.
- IDLE:
  - If miss_cache=1, latch base = {miss_pc[31:2+log2(LINE_WORDS)], zeros}, set cnt=0, go to REQ.
  - refill_busy rises in the cycle after the miss is seen.
- REQ:
  - mem_req=1 and mem_addr = base + 4*cnt.
  - Both are held stable until mem_ack.
  - On mem_ack, capture mem_rdata into a data register and go to WRITE.
  - If mem_ack and mem_req are high in the same cycle, that counts as completion; there is no minimum wait.
  - Only one request is outstanding at a time.
- WRITE (exactly one cycle):
  - save_to_cache=1.
  - cache_input = captured word.
  - fill_index = addr[8:2] and fill_tag = addr[31:9], where addr = base + 4*cnt.
  - mem_req=0.
  - If cnt==LINE_WORDS-1, go to DONE; otherwise cnt++ and go to REQ.
- DONE (one cycle): refill_done=1, refill_busy=1, then go to IDLE.
- refill_busy is 1 in REQ, WRITE and DONE, and 0 in IDLE.
- Minimum burst latency with mem_ack returned in the same cycle as mem_req: 2*LINE_WORDS+1 cycles from acceptance to the DONE exit.
- miss_cache while not in IDLE is ignored and not queued. A miss still present after DONE is re-evaluated in IDLE.
- Address arithmetic is 32-bit. The burst never crosses a line boundary; cnt wraps only via the reset to 0 on acceptance.
- A 32-bit instruction at pc[1]=1 in the last word of a line straddles two lines. The L1 raises a second miss, which this block serves as an independent burst; no special case here.
- mem_ack outside REQ is ignored.

Decomposition:
- Shared package icache_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_REQ=2'd1, ST_WRITE=2'd2, ST_DONE=2'd3;
  - INDEX_W/TAG_W constants;
  - the pc-field slice positions (index [8:2], tag [31:9]), so instr_cache_L1 and this block agree.
- There is no sub-module. Counter, address adder and FSM live in one module.

Test Plan:
1. Reset, then miss_cache=1 with miss_pc=0x0000_1046, mem_ack returned one cycle after each request -> mem_addr sequence 0x1040, 0x1044, 0x1048, 0x104C. Each word followed by save_to_cache with fill_index=0x10..0x13 and fill_tag=0x8. refill_done pulses once and busy drops the next cycle.
2. mem_ack held high permanently -> burst completes in exactly 9 cycles after acceptance. mem_addr never changes while a request is pending.
3. mem_ack delayed 5 cycles on word 2 -> mem_req and mem_addr=0x1048 stay stable for all 5 cycles, with no save_to_cache during the wait.
4. Second miss_cache pulse (pc=0x2000) during an active burst -> ignored. Only the 0x1040 line is written.
5. Reset asserted in REQ after 2 words are written -> next cycle mem_req=0, refill_busy=0, and no further writes. A new miss then restarts from word 0.
6. miss_pc=0xFFFF_FFFE -> addresses 0xFFFF_FFF0..0xFFFF_FFFC, fill_tag=0x7FFFFF, and no wrap to 0x0.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared refill FSM encoding and PC field positions for the L1 icache
package icache_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int INDEX_W   = 7;
    localparam int TAG_W     = 23;
    localparam int INDEX_LSB = 2;
    localparam int TAG_LSB   = 9;

    // instr_cache_L1 uses the same helpers so both sides slice the PC identically
    function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[INDEX_LSB +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[TAG_LSB +: TAG_W];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - line refill engine between instruction memory and the L1 icache
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int INDEX_W    = icache_pkg::INDEX_W,
    parameter int TAG_W      = icache_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               miss_cache,
    input  logic [31:0]        miss_pc,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [31:0]        mem_rdata,
    output logic               save_to_cache,
    output logic [31:0]        cache_input,
    output logic [INDEX_W-1:0] fill_index,
    output logic [TAG_W-1:0]   fill_tag,
    output logic               refill_busy,
    output logic               refill_done
);
    import icache_pkg::*;

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      addr;

    // Line-aligned base plus word offset; the offset never carries past the line
    assign addr = base_q + {{(30 - CNT_W){1'b0}}, cnt_q, 2'b00};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_cache) begin
                    base_d  = miss_pc & LINE_MASK;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

    // Data-path outputs are forced to zero outside the state that qualifies them
    always_comb begin
        mem_req       = (state_q == ST_REQ);
        save_to_cache = (state_q == ST_WRITE);
        refill_busy   = (state_q != ST_IDLE);
        refill_done   = (state_q == ST_DONE);
        mem_addr      = mem_req ? addr : 32'd0;
        cache_input   = save_to_cache ? data_q : 32'd0;
        fill_index    = save_to_cache ? addr[INDEX_LSB +: INDEX_W] : '0;
        fill_tag      = save_to_cache ? addr[TAG_LSB +: TAG_W] : '0;
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - scoreboard bench for icache_refill_ctrl with a random memory responder
module tb_icache_refill_ctrl;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_cache;
    logic [31:0] miss_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        save_to_cache;
    logic [31:0] cache_input;
    logic [6:0]  fill_index;
    logic [22:0] fill_tag;
    logic        refill_busy;
    logic        refill_done;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.LINE_WORDS(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .miss_cache    (miss_cache),
        .miss_pc       (miss_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .save_to_cache (save_to_cache),
        .cache_input   (cache_input),
        .fill_index    (fill_index),
        .fill_tag      (fill_tag),
        .refill_busy   (refill_busy),
        .refill_done   (refill_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  idx;
        logic [22:0] tag;
    } wr_t;

    logic [31:0] aq_mon[$];
    logic [31:0] aq_resp[$];
    wr_t         wq[$];

    // Reference model: a burst is "line address list pending" until LW real acks,
    // then one write cycle and one done cycle before the engine is free again.
    int  m_ph = 0;
    int  m_acks = 0;
    logic resp_real = 1'b0;

    always @(posedge clk) begin
        logic [31:0] base;
        if (reset) begin
            m_ph = 0;
            aq_mon.delete();
            aq_resp.delete();
            wq.delete();
        end else begin
            case (m_ph)
                0: if (miss_cache === 1'b1) begin
                    base = miss_pc & ~(32'(LW * 4) - 32'd1);
                    for (int k = 0; k < LW; k++) begin
                        aq_mon.push_back(base + 32'(4 * k));
                        aq_resp.push_back(base + 32'(4 * k));
                    end
                    m_acks = 0;
                    m_ph   = 1;
                end
                1: if (resp_real) begin
                    m_acks++;
                    if (m_acks == LW) m_ph = 2;
                end
                2: m_ph = 3;
                default: m_ph = 0;
            endcase
        end
    end

    // Memory responder
    int   dmin = 1, dmax = 1;
    bit   hold = 1'b0;
    int   slow_word = -1, slow_delay = 0;
    bit   r_pending = 1'b0;
    int   r_wait = 0;

    initial begin
        logic [31:0] a;
        int w;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                r_pending = 1'b0;
                resp_real = 1'b0;
                mem_ack   = 1'b0;
            end else if (mem_req === 1'b1) begin
                if (!r_pending) begin
                    r_pending = 1'b1;
                    w = LW - aq_resp.size();
                    if (hold) r_wait = 0;
                    else if (w == slow_word) r_wait = slow_delay;
                    else r_wait = $urandom_range(dmax, dmin);
                end
                if (r_wait == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                    resp_real = 1'b1;
                    r_pending = 1'b0;
                    chk("resp_addr_queued", 64'(aq_resp.size() != 0), 64'd1);
                    if (aq_resp.size() != 0) begin
                        a = aq_resp.pop_front();
                        wq.push_back('{data: mem_rdata, idx: 7'((a >> 2) & 32'h7F), tag: 23'(a >> 9)});
                    end
                end else begin
                    r_wait--;
                    mem_ack   = 1'b0;
                    resp_real = 1'b0;
                end
            end else begin
                r_pending = 1'b0;
                resp_real = 1'b0;
                mem_ack   = hold ? 1'b1 : ($urandom_range(3, 0) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor
    bit          mon_pending = 1'b0;
    logic [31:0] cur_addr = 32'd0;
    int          saves_seen = 0, dones_seen = 0, mon_run = 0;
    logic [31:0] addr_log[$];
    logic [6:0]  idx_log[$];
    logic [22:0] tag_log[$];
    int          run_log[$];

    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            chk("refill_busy", 64'(refill_busy), 64'(m_ph != 0));
            chk("refill_done", 64'(refill_done), 64'(m_ph == 3));
            if (mem_req === 1'b1) begin
                if (!mon_pending) begin
                    chk("req_expected", 64'(aq_mon.size() != 0), 64'd1);
                    if (aq_mon.size() != 0) cur_addr = aq_mon.pop_front();
                    mon_pending = 1'b1;
                    mon_run     = 0;
                    addr_log.push_back(mem_addr);
                end
                mon_run++;
                chk("mem_addr", 64'(mem_addr), 64'(cur_addr));
            end else begin
                if (mon_pending) run_log.push_back(mon_run);
                mon_pending = 1'b0;
            end
            if (save_to_cache === 1'b1) begin
                saves_seen++;
                idx_log.push_back(fill_index);
                tag_log.push_back(fill_tag);
                chk("write_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    chk("cache_input", 64'(cache_input), 64'(e.data));
                    chk("fill_index", 64'(fill_index), 64'(e.idx));
                    chk("fill_tag", 64'(fill_tag), 64'(e.tag));
                end
            end
            if (refill_done === 1'b1) dones_seen++;
        end
    end

    task automatic clear_logs();
        addr_log.delete();
        idx_log.delete();
        tag_log.delete();
        run_log.delete();
    endtask

    task automatic start_miss(input logic [31:0] pc);
        miss_cache = 1'b1;
        miss_pc    = pc;
        @(negedge clk);
        miss_cache = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit done;
        done = 1'b0;
        lat  = 0;
        for (int g = 0; g < 300; g++) begin
            if (refill_busy === 1'b1) lat++;
            if (refill_done === 1'b1) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("burst_completes", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int lat, d0, s0;
        bit ok;
        reset      = 1'b1;
        miss_cache = 1'b0;
        miss_pc    = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_save", 64'(save_to_cache), 64'd0);
        chk("rst_cache_input", 64'(cache_input), 64'd0);
        chk("rst_fill_index", 64'(fill_index), 64'd0);
        chk("rst_fill_tag", 64'(fill_tag), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // ack one cycle after each request
        clear_logs();
        d0 = dones_seen;
        dmin = 1; dmax = 1;
        start_miss(32'h0000_1046);
        wait_done(lat);
        chk("t1_nwords", 64'(addr_log.size()), 64'(LW));
        for (int k = 0; k < LW && k < addr_log.size() && k < idx_log.size(); k++) begin
            chk("t1_addr", 64'(addr_log[k]), 64'(32'h1040 + 32'(4 * k)));
            chk("t1_index", 64'(idx_log[k]), 64'(8'h10 + 8'(k)));
            chk("t1_tag", 64'(tag_log[k]), 64'h8);
        end
        chk("t1_done_once", 64'(dones_seen - d0), 64'd1);
        chk("t1_busy_drop", 64'(refill_busy), 64'd0);

        // ack held high permanently: minimum latency
        hold = 1'b1;
        start_miss(32'h0000_1046);
        wait_done(lat);
        chk("t2_latency", 64'(lat), 64'(2 * LW + 1));
        hold = 1'b0;

        // word 2 stalled five cycles
        clear_logs();
        dmin = 0; dmax = 0; slow_word = 2; slow_delay = 5;
        start_miss(32'h0000_1046);
        wait_done(lat);
        slow_word = -1;
        chk("t3_nruns", 64'(run_log.size()), 64'(LW));
        if (run_log.size() == LW) begin
            chk("t3_run0", 64'(run_log[0]), 64'd1);
            chk("t3_run2", 64'(run_log[2]), 64'd6);
            chk("t3_addr2", 64'(addr_log[2]), 64'h1048);
        end

        // second miss during a burst is dropped
        clear_logs();
        dmin = 2; dmax = 2;
        miss_cache = 1'b1;
        miss_pc    = 32'h0000_1046;
        @(negedge clk);
        miss_cache = 1'b0;
        repeat (3) @(negedge clk);
        start_miss(32'h0000_2000);
        wait_done(lat);
        repeat (3) @(negedge clk);
        chk("t4_nwrites", 64'(tag_log.size()), 64'(LW));
        foreach (tag_log[k]) chk("t4_tag", 64'(tag_log[k]), 64'h8);

        // reset mid-burst after two writes
        dmin = 3; dmax = 3;
        s0 = saves_seen;
        start_miss(32'h0000_1046);
        ok = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (saves_seen - s0 >= 2 && mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_reached_word2", 64'(ok), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_req_dropped", 64'(mem_req), 64'd0);
        chk("t5_busy_dropped", 64'(refill_busy), 64'd0);
        chk("t5_no_save", 64'(save_to_cache), 64'd0);
        reset = 1'b0;
        s0 = saves_seen;
        repeat (4) @(negedge clk);
        chk("t5_no_more_writes", 64'(saves_seen - s0), 64'd0);
        clear_logs();
        start_miss(32'h0000_1046);
        wait_done(lat);
        chk("t5_restart_n", 64'(idx_log.size()), 64'(LW));
        if (idx_log.size() != 0) chk("t5_restart_word0", 64'(idx_log[0]), 64'h10);

        // top of address space
        clear_logs();
        dmin = 0; dmax = 2;
        start_miss(32'hFFFF_FFFE);
        wait_done(lat);
        chk("t6_nwords", 64'(addr_log.size()), 64'(LW));
        for (int k = 0; k < LW && k < addr_log.size() && k < tag_log.size(); k++) begin
            chk("t6_addr", 64'(addr_log[k]), 64'(32'hFFFF_FFF0 + 32'(4 * k)));
            chk("t6_tag", 64'(tag_log[k]), 64'h7FFFFF);
            chk("t6_index", 64'(idx_log[k]), 64'(8'h7C + 8'(k)));
        end

        // random traffic with occasional resets and held misses
        dmin = 0; dmax = 3;
        for (int c = 0; c < 1500; c++) begin
            miss_cache = ($urandom_range(5, 0) == 0);
            miss_pc    = $urandom;
            reset      = ($urandom_range(199, 0) == 0);
            @(negedge clk);
        end
        miss_cache = 1'b0;
        reset      = 1'b0;
        repeat (60) @(negedge clk);
        chk("drain_busy", 64'(refill_busy), 64'd0);
        chk("drain_writes", 64'(wq.size()), 64'd0);
        chk("drain_reqs", 64'(aq_mon.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
